// File: rtl/pcs_tx_pkg.sv
// Shared types and constants for the 32-bit TX PCS path.
// Holds the scheduler state enum and the gearbox period geometry.
package pcs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    RUN,
    DRAIN
  } sched_state_t;

  localparam int GB_SEQ_MAX = 32;
  localparam int GB_PERIOD  = 66;
  localparam int SEQ_W      = 6;

endpackage

// File: rtl/tx_sched_pause_gen.sv
// Maps the schedule cycle to gearbox sequence, encoder phase and pauses.
// Ports: cyc in; gb_seq, enc_phase, gb_pause, xgmii_pause out (comb).
module tx_sched_pause_gen
  import pcs_tx_pkg::*;
#(
  parameter int SEQ_MAX    = GB_SEQ_MAX,
  parameter int PAUSE_LEAD = 1,
  parameter int CYC_W      = 7
) (
  input  logic [CYC_W-1:0] cyc,
  output logic [SEQ_W-1:0] gb_seq,
  output logic             enc_phase,
  output logic             gb_pause,
  output logic             xgmii_pause
);

  localparam int SW = CYC_W + 1;
  localparam logic [SW-1:0] PERIOD = SW'(2 * SEQ_MAX + 2);
  localparam logic [SW-1:0] PSTART = SW'(2 * SEQ_MAX);
  localparam logic [SW-1:0] LEAD   = SW'(PAUSE_LEAD);

  logic [SW-1:0] ext;
  logic [SW-1:0] lead_sum;
  logic [SW-1:0] lead_mod;

  // The MAC pause is the gearbox pause window seen PAUSE_LEAD
  // cycles early, wrapping around the period boundary.
  always_comb begin
    ext         = {1'b0, cyc};
    lead_sum    = ext + LEAD;
    lead_mod    = (lead_sum >= PERIOD) ? lead_sum - PERIOD : lead_sum;
    gb_seq      = SEQ_W'(cyc >> 1);
    enc_phase   = cyc[0];
    gb_pause    = ext >= PSTART;
    xgmii_pause = lead_mod >= PSTART;
  end

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// TX PCS scheduler: 66-cycle encoder/gearbox schedule with bring-up,
// drain and resync; early XGMII pause to the MAC; sticky overrun flag.
// Ports: i_clk, i_reset_n (sync, active-low), i_tx_en, i_gb_ready,
//   i_mac_valid, i_err_clr in; o_xgmii_pause, o_enc_phase, o_enc_valid,
//   o_gb_seq, o_gb_pause, o_running, o_resync, o_overrun_err out.
// Optional XGMII_TX_SCHED_STATS_EN adds o_pause_cnt / o_overrun_cnt.
module xgmii_tx_scheduler
  import pcs_tx_pkg::*;
#(
  parameter int SEQ_MAX     = GB_SEQ_MAX,
  parameter int PAUSE_LEAD  = 1,
  parameter int START_DELAY = 4,
  parameter int CYC_W       = 7
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tx_en,
  input  logic             i_gb_ready,
  input  logic             i_mac_valid,
  input  logic             i_err_clr,
  output logic             o_xgmii_pause,
  output logic             o_enc_phase,
  output logic             o_enc_valid,
  output logic [SEQ_W-1:0] o_gb_seq,
  output logic             o_gb_pause,
  output logic             o_running,
  output logic             o_resync,
  output logic             o_overrun_err
`ifdef XGMII_TX_SCHED_STATS_EN
  ,
  output logic [15:0]      o_pause_cnt,
  output logic [15:0]      o_overrun_cnt
`endif
);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * SEQ_MAX + 1);
  localparam logic [7:0]       CNT_LAST = 8'(START_DELAY - 1);

  sched_state_t     state;
  sched_state_t     state_nx;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_nx;
  logic [CYC_W-1:0] cyc_inc;
  logic [7:0]       ready_cnt;
  logic [7:0]       ready_cnt_nx;

  logic [SEQ_W-1:0] pg_seq;
  logic             pg_phase;
  logic             pg_pause;
  logic             pg_xpause;

  logic             active_nx;
  logic             xgmii_pause_d;
  logic             enc_phase_d;
  logic             enc_valid_d;
  logic [SEQ_W-1:0] gb_seq_d;
  logic             gb_pause_d;
  logic             running_d;
  logic             resync_d;
  logic             overrun_set;
  logic             overrun_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cyc       <= '0;
      ready_cnt <= '0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc_nx;
      ready_cnt <= ready_cnt_nx;
    end
  end

  // Loss of ready wins over everything once the schedule is live;
  // a drain always finishes the half-block pair it is in.
  always_comb begin
    state_nx     = state;
    cyc_nx       = cyc;
    ready_cnt_nx = '0;
    cyc_inc      = (cyc == CYC_LAST) ? '0 : cyc + 1'b1;
    unique case (state)
      IDLE: begin
        cyc_nx = '0;
        if (i_tx_en) state_nx = WAIT_READY;
      end
      WAIT_READY: begin
        cyc_nx = '0;
        if (!i_tx_en) begin
          state_nx = IDLE;
        end else if (i_gb_ready) begin
          if (ready_cnt == CNT_LAST) state_nx = RUN;
          else ready_cnt_nx = ready_cnt + 8'd1;
        end
      end
      RUN: begin
        if (!i_gb_ready) begin
          state_nx = WAIT_READY;
          cyc_nx   = '0;
        end else begin
          cyc_nx = cyc_inc;
          if (!i_tx_en) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_gb_ready) begin
          state_nx = WAIT_READY;
          cyc_nx   = '0;
        end else if (cyc[0]) begin
          state_nx = IDLE;
          cyc_nx   = '0;
        end else begin
          cyc_nx = cyc_inc;
        end
      end
      default: begin
        state_nx = IDLE;
        cyc_nx   = '0;
      end
    endcase
  end

  tx_sched_pause_gen #(
    .SEQ_MAX    (SEQ_MAX),
    .PAUSE_LEAD (PAUSE_LEAD),
    .CYC_W      (CYC_W)
  ) u_pause_gen (
    .cyc         (cyc_nx),
    .gb_seq      (pg_seq),
    .enc_phase   (pg_phase),
    .gb_pause    (pg_pause),
    .xgmii_pause (pg_xpause)
  );

  // Outputs are decoded from the next state so the registered copies
  // always describe the state/cycle that is current after the edge.
  always_comb begin
    active_nx     = (state_nx == RUN) || (state_nx == DRAIN);
    running_d     = state_nx == RUN;
    enc_phase_d   = active_nx & pg_phase;
    gb_seq_d      = active_nx ? pg_seq : '0;
    gb_pause_d    = active_nx & pg_pause;
    enc_valid_d   = active_nx & ~pg_pause;
    xgmii_pause_d = (state_nx != RUN) | pg_xpause;
    resync_d      = (state == RUN) & ~i_gb_ready;
    overrun_set   = (state == RUN) & o_xgmii_pause & i_mac_valid;
    overrun_d     = overrun_set | (o_overrun_err & ~i_err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_xgmii_pause <= 1'b1;
      o_enc_phase   <= 1'b0;
      o_enc_valid   <= 1'b0;
      o_gb_seq      <= '0;
      o_gb_pause    <= 1'b0;
      o_running     <= 1'b0;
      o_resync      <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      o_xgmii_pause <= xgmii_pause_d;
      o_enc_phase   <= enc_phase_d;
      o_enc_valid   <= enc_valid_d;
      o_gb_seq      <= gb_seq_d;
      o_gb_pause    <= gb_pause_d;
      o_running     <= running_d;
      o_resync      <= resync_d;
      o_overrun_err <= overrun_d;
    end
  end

`ifdef XGMII_TX_SCHED_STATS_EN
  // First cycle of the pause slot marks one gearbox pause.
  logic pause_slot;
  assign pause_slot = o_gb_pause & ~o_enc_phase;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pause_cnt   <= '0;
      o_overrun_cnt <= '0;
    end else if (i_err_clr) begin
      o_pause_cnt   <= {15'd0, pause_slot};
      o_overrun_cnt <= {15'd0, overrun_set};
    end else begin
      if (pause_slot && o_pause_cnt != 16'hFFFF)
        o_pause_cnt <= o_pause_cnt + 16'd1;
      if (overrun_set && o_overrun_cnt != 16'hFFFF)
        o_overrun_cnt <= o_overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Bench for xgmii_tx_scheduler: directed bring-up/steady/overrun/
// resync/drain scenarios, then randomized traffic against a model.
module tb_xgmii_tx_scheduler;

  localparam int SEQ_MAX     = 32;
  localparam int PAUSE_LEAD  = 1;
  localparam int START_DELAY = 4;
  localparam int PERIOD      = 2 * SEQ_MAX + 2;

  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_RUN   = 2;
  localparam int S_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic gb_ready = 1'b0;
  logic mac_valid = 1'b0;
  logic err_clr = 1'b0;

  logic       xgmii_pause;
  logic       enc_phase;
  logic       enc_valid;
  logic [5:0] gb_seq;
  logic       gb_pause;
  logic       running;
  logic       resync;
  logic       overrun_err;
`ifdef XGMII_TX_SCHED_STATS_EN
  logic [15:0] pause_cnt;
  logic [15:0] overrun_cnt;
`endif

  always #5 clk = ~clk;

  xgmii_tx_scheduler #(
    .SEQ_MAX     (SEQ_MAX),
    .PAUSE_LEAD  (PAUSE_LEAD),
    .START_DELAY (START_DELAY),
    .CYC_W       (7)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_tx_en       (tx_en),
    .i_gb_ready    (gb_ready),
    .i_mac_valid   (mac_valid),
    .i_err_clr     (err_clr),
    .o_xgmii_pause (xgmii_pause),
    .o_enc_phase   (enc_phase),
    .o_enc_valid   (enc_valid),
    .o_gb_seq      (gb_seq),
    .o_gb_pause    (gb_pause),
    .o_running     (running),
    .o_resync      (resync),
    .o_overrun_err (overrun_err)
`ifdef XGMII_TX_SCHED_STATS_EN
    ,
    .o_pause_cnt   (pause_cnt),
    .o_overrun_cnt (overrun_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int shown  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s: actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: scheduler position as plain integers.
  int m_st    = S_IDLE;
  int m_cyc   = 0;
  int m_ready = 0;
  bit m_resync = 1'b0;
  bit m_err    = 1'b0;
  int m_pcnt   = 0;
  int m_ocnt   = 0;

  function automatic bit m_active();
    return (m_st == S_RUN) || (m_st == S_DRAIN);
  endfunction

  function automatic bit m_gp();
    return m_active() && (m_cyc >= 2 * SEQ_MAX);
  endfunction

  function automatic bit m_xp();
    if (m_st != S_RUN) return 1'b1;
    return ((m_cyc + PAUSE_LEAD) % PERIOD) >= 2 * SEQ_MAX;
  endfunction

  task automatic model_step();
    bit ovr;
    bit slot;
    if (!rst_n) begin
      m_st = S_IDLE; m_cyc = 0; m_ready = 0;
      m_resync = 1'b0; m_err = 1'b0;
      m_pcnt = 0; m_ocnt = 0;
      return;
    end
    ovr  = (m_st == S_RUN) && m_xp() && mac_valid;
    slot = m_gp() && (m_cyc % 2 == 0);
    m_resync = (m_st == S_RUN) && !gb_ready;
    m_err = ovr || (m_err && !err_clr);
    if (err_clr) begin
      m_pcnt = int'(slot);
      m_ocnt = int'(ovr);
    end else begin
      if (slot && m_pcnt < 65535) m_pcnt++;
      if (ovr && m_ocnt < 65535) m_ocnt++;
    end
    case (m_st)
      S_IDLE: begin
        m_ready = 0;
        if (tx_en) m_st = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_en) begin
          m_st = S_IDLE; m_ready = 0;
        end else if (gb_ready) begin
          m_ready++;
          if (m_ready == START_DELAY) begin
            m_st = S_RUN; m_cyc = 0; m_ready = 0;
          end
        end else begin
          m_ready = 0;
        end
      end
      S_RUN: begin
        if (!gb_ready) begin
          m_st = S_WAIT; m_cyc = 0;
        end else begin
          m_cyc = (m_cyc + 1) % PERIOD;
          if (!tx_en) m_st = S_DRAIN;
        end
      end
      default: begin
        if (!gb_ready) begin
          m_st = S_WAIT; m_cyc = 0;
        end else if (m_cyc % 2 == 1) begin
          m_st = S_IDLE; m_cyc = 0;
        end else begin
          m_cyc++;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk1("cmp_running", running, m_st == S_RUN);
    chk1("cmp_xgmii_pause", xgmii_pause, m_xp());
    chk1("cmp_gb_pause", gb_pause, m_gp());
    chk1("cmp_enc_valid", enc_valid, m_active() && !m_gp());
    chk1("cmp_enc_phase", enc_phase, m_active() && (m_cyc % 2 == 1));
    chkn("cmp_gb_seq", int'(gb_seq), m_active() ? m_cyc / 2 : 0);
    chk1("cmp_resync", resync, m_resync);
    chk1("cmp_overrun", overrun_err, m_err);
`ifdef XGMII_TX_SCHED_STATS_EN
    chkn("cmp_pause_cnt", int'(pause_cnt), m_pcnt);
    chkn("cmp_overrun_cnt", int'(overrun_cnt), m_ocnt);
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for o_running, bounded; returns number of cycles waited.
  task automatic wait_run(output int n);
    n = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int gp_n;
    int xp_n;
    int ev_n;
`ifdef XGMII_TX_SCHED_STATS_EN
    int pc0;
`endif
    step(3);
    chk1("rst_xgmii_pause", xgmii_pause, 1'b1);
    chk1("rst_running", running, 1'b0);
    chk1("rst_enc_valid", enc_valid, 1'b0);
    chkn("rst_gb_seq", int'(gb_seq), 0);

    // One edge IDLE->WAIT_READY, then four ready cycles.
    rst_n = 1'b1; tx_en = 1'b1; gb_ready = 1'b1;
    wait_run(n);
    chkn("bringup_latency", n, 5);
    chkn("bringup_seq", int'(gb_seq), 0);
    chk1("bringup_phase", enc_phase, 1'b0);

    step(63);
    chk1("c63_xpause", xgmii_pause, 1'b1);
    chk1("c63_gbpause", gb_pause, 1'b0);
    step(1);
    chk1("c64_xpause", xgmii_pause, 1'b1);
    chk1("c64_gbpause", gb_pause, 1'b1);
    chkn("c64_seq", int'(gb_seq), 32);
    chk1("c64_enc_valid", enc_valid, 1'b0);
    step(1);
    chk1("c65_xpause", xgmii_pause, 1'b0);
    chk1("c65_gbpause", gb_pause, 1'b1);
    step(1);
    chk1("c0_gbpause", gb_pause, 1'b0);
    chk1("c0_enc_valid", enc_valid, 1'b1);

    gp_n = 0; xp_n = 0; ev_n = 0;
`ifdef XGMII_TX_SCHED_STATS_EN
    pc0 = int'(pause_cnt);
`endif
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step(1);
      gp_n += int'(gb_pause);
      xp_n += int'(xgmii_pause);
      ev_n += int'(!enc_valid);
    end
    chkn("steady_gbpause_cycles", gp_n, 6);
    chkn("steady_xpause_cycles", xp_n, 6);
    chkn("steady_encvalid_low", ev_n, 6);
`ifdef XGMII_TX_SCHED_STATS_EN
    chkn("steady_pause_cnt_delta", int'(pause_cnt) - pc0, 3);
`endif

    step(63);
    mac_valid = 1'b1;
    step(1);
    chk1("ovr_set", overrun_err, 1'b1);
    err_clr = 1'b1;
    step(1);
    chk1("ovr_set_wins", overrun_err, 1'b1);
    mac_valid = 1'b0; err_clr = 1'b0;
    step(1);
    chk1("ovr_sticky", overrun_err, 1'b1);
    err_clr = 1'b1;
    step(1);
    chk1("ovr_cleared", overrun_err, 1'b0);
    err_clr = 1'b0; mac_valid = 1'b1;
    step(1);
    chk1("ovr_unpaused", overrun_err, 1'b0);
    mac_valid = 1'b0;

    step(18);
    chkn("glitch_at_seq10", int'(gb_seq), 10);
    gb_ready = 1'b0;
    step(1);
    chk1("glitch_resync", resync, 1'b1);
    chk1("glitch_xpause", xgmii_pause, 1'b1);
    chk1("glitch_running", running, 1'b0);
    gb_ready = 1'b1;
    step(1);
    chk1("glitch_resync_pulse", resync, 1'b0);
    step(1);
    gb_ready = 1'b0;
    step(1);
    gb_ready = 1'b1;
    wait_run(n);
    chkn("glitch_restart", n, 4);

    step(10);
    tx_en = 1'b0;
    step(1);
    chk1("drain_running", running, 1'b0);
    chk1("drain_xpause", xgmii_pause, 1'b1);
    chk1("drain_enc_valid", enc_valid, 1'b1);
    chkn("drain_seq", int'(gb_seq), 5);
    step(1);
    chk1("drain_idle_valid", enc_valid, 1'b0);
    chk1("drain_idle_phase", enc_phase, 1'b0);

    tx_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (tx_en) tx_en = ($urandom_range(0, 149) != 0);
      else tx_en = ($urandom_range(0, 9) == 0);
      gb_ready  = ($urandom_range(0, 59) != 0);
      mac_valid = $urandom_range(0, 1) != 0;
      err_clr   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_scheduler.md
Name: xgmii_tx_scheduler

Overview:
- Sequences the 32-bit TX PCS path: encoder, 64b/66b gearbox and the MAC-facing XGMII pause.
- Maintains a 66-cycle schedule: 33 block slots of 2 cycles each.
  - Slots 0..31 carry encoded blocks.
  - Slot 32 is the gearbox pause slot, which absorbs 32 blocks x 2 sync-header bits.
- Drives the encoder's half-block phase, the gearbox sequence/pause, and an early XGMII pause to the MAC.
- Handles bring-up, drain and resync when the gearbox or serializer loses readiness.

Parameters:
- SEQ_MAX, 32, last sequence value; the slot where o_gb_seq == SEQ_MAX is the pause slot.
- PAUSE_LEAD, 1, cycles by which o_xgmii_pause precedes o_gb_pause; legal range 0..3.
- START_DELAY, 4, consecutive cycles i_gb_ready must be high before RUN; legal range 1..255.
- CYC_W, 7, width of the internal cycle counter; must satisfy 2^CYC_W > 2*(SEQ_MAX+1).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_tx_en  in  1  transmit enable from management
- i_gb_ready  in  1  gearbox/serializer ready (lock)
- i_mac_valid  in  1  MAC is presenting a new XGMII word this cycle
- i_err_clr  in  1  clears o_overrun_err
- o_xgmii_pause  out  1  MAC must hold its XGMII word while high
- o_enc_phase  out  1  0 = first half of block, 1 = second half; aligns the encoder cycle counter
- o_enc_valid  out  1  encoder output word is valid for the gearbox
- o_gb_seq  out  6  gearbox sequence number, 0..SEQ_MAX
- o_gb_pause  out  1  gearbox consumes no word this cycle
- o_running  out  1  state == RUN
- o_resync  out  1  one-cycle pulse on RUN -> WAIT_READY
- o_overrun_err  out  1  sticky; MAC supplied data while paused

Behaviour:
- Reset values:
  - state = IDLE, cyc = 0, ready_cnt = 0.
  - o_xgmii_pause = 1; every other output = 0.
- Interface rules fixed for this block: one clock; reset is synchronous and active-low.
- All outputs are registered. Input-to-output latency is 1 cycle.
- State machine:
  - IDLE:
    - o_xgmii_pause = 1, o_enc_valid = 0, cyc held at 0.
    - i_tx_en = 1 -> WAIT_READY.
  - WAIT_READY:
    - ready_cnt increments while i_gb_ready = 1 and clears to 0 when i_gb_ready = 0.
    - When ready_cnt reaches START_DELAY-1 with i_gb_ready = 1 -> RUN, cyc = 0.
    - i_tx_en = 0 -> IDLE; this takes priority.
  - RUN:
    - cyc increments each cycle and wraps 2*SEQ_MAX+1 -> 0 (65 -> 0 at default).
    - o_enc_phase = cyc[0]; o_gb_seq = cyc >> 1.
    - o_gb_pause = 1 iff cyc >= 2*SEQ_MAX.
    - o_enc_valid = !o_gb_pause.
    - o_xgmii_pause = 1 iff ((cyc + PAUSE_LEAD) mod (2*SEQ_MAX+2)) >= 2*SEQ_MAX.
      - This is exactly 2 cycles per period, leading the gearbox pause by PAUSE_LEAD.
    - i_gb_ready = 0 -> WAIT_READY. This has priority over i_tx_en.
      - o_resync pulses for 1 cycle; o_xgmii_pause = 1 from the next cycle.
    - i_tx_en = 0 (with i_gb_ready = 1) -> DRAIN.
  - DRAIN:
    - o_xgmii_pause = 1; cyc keeps advancing so the current block completes.
    - When cyc is odd, the block is complete: go to IDLE, and o_enc_valid = 0 next cycle.
    - i_gb_ready = 0 -> WAIT_READY.
    - i_tx_en re-asserted in DRAIN is ignored until IDLE is reached.
- Overrun:
  - In RUN, i_mac_valid = 1 while o_xgmii_pause = 1 sets o_overrun_err.
  - i_err_clr clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-RUN returns all state and outputs to reset values on the next edge. No partial block is flushed.

Optional Feature:
- Macro: XGMII_TX_SCHED_STATS_EN.
- With the macro defined:
  - Adds o_pause_cnt (16-bit, saturating), incremented once per gearbox pause slot.
  - Adds o_overrun_cnt (16-bit, saturating), incremented per overrun cycle.
  - i_err_clr also zeroes both counters.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package pcs_tx_pkg holds:
  - sched_state_t enum (IDLE, WAIT_READY, RUN, DRAIN);
  - GB_SEQ_MAX = 32 and GB_PERIOD = 66;
  - SEQ_W = 6.
- One natural sub-module: tx_sched_pause_gen, which maps cyc to o_gb_pause, o_xgmii_pause and o_gb_seq, parameterised by PAUSE_LEAD.

Test Plan:
- Bring-up: reset, i_tx_en = 1, i_gb_ready = 1 -> o_running rises on the 4th ready cycle at the earliest (START_DELAY = 4); first o_gb_seq = 0, o_enc_phase = 0.
- Steady state over 3 periods (198 cycles) -> o_gb_pause high exactly at cyc 64,65; o_xgmii_pause high at cyc 63,64 (PAUSE_LEAD = 1); o_gb_seq counts 0..32; o_enc_valid low only when o_gb_pause is high.
- Ready glitch: i_gb_ready dropped at cyc 20 -> o_resync pulse, o_xgmii_pause = 1; 2 ready cycles then another drop -> ready_cnt restarts and no RUN until 4 consecutive ready cycles.
- Drain: i_tx_en dropped at cyc 10 (even) -> DRAIN for 1 cycle, IDLE after cyc 11, o_enc_valid = 0.
- Overrun: i_mac_valid = 1 at cyc 63 -> o_overrun_err = 1 and stays set; i_err_clr together with a new overrun -> remains 1; i_err_clr alone -> 0.
- PAUSE_LEAD = 0 and 3 builds: o_xgmii_pause at cyc 64,65 and 61,62 respectively; with XGMII_TX_SCHED_STATS_EN, o_pause_cnt = 3 after 3 periods.
